// File: rtl/cosim_arb_pkg.sv
// Shared types for the co-simulation commit arbiter: event record, FSM states, hart-id width helper.
package cosim_arb_pkg;

    localparam int CA_XLEN      = 64;
    localparam int CA_INST_BITS = 32;

    typedef struct packed {
        logic                    trap;
        logic [CA_XLEN-1:0]      pc;
        logic [CA_INST_BITS-1:0] inst;
        logic [CA_XLEN-1:0]      wdata;
    } cosim_evt_t;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} arb_state_e;

    function automatic int hart_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cosim_commit_fifo.sv
// Per-hart event queue: compacts up to CW valid lanes plus an optional trailing trap per push,
// single pop, registered ready computed from the post-update occupancy.
module cosim_commit_fifo
    import cosim_arb_pkg::*;
#(
    parameter int CW        = 2,
    parameter int DEPTH     = 8,
    parameter int XLEN      = CA_XLEN,
    parameter int INST_BITS = CA_INST_BITS
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [CW-1:0]                       push_valid,
    input  logic [CW-1:0][XLEN-1:0]             push_pc,
    input  logic [CW-1:0][INST_BITS-1:0]        push_inst,
    input  logic [CW-1:0][XLEN-1:0]             push_wdata,
    input  logic                                push_trap,
    input  logic [XLEN-1:0]                     push_cause,
    input  logic                                pop,
    output logic                                ready,
    output cosim_evt_t                          head,
    output cosim_evt_t                          head_nxt,
    output logic [$clog2(DEPTH):0]              occupancy,
    output logic [$clog2(DEPTH):0]              free
);

    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] ptr_t;

    cosim_evt_t mem [DEPTH];
    ptr_t       wr_ptr, rd_ptr, n_push, count_nxt;
    ptr_t       slot [CW+1];
    logic       accept;

    assign accept    = ready & ((|push_valid) | push_trap);
    assign occupancy = wr_ptr - rd_ptr;
    assign free      = ptr_t'(DEPTH) - occupancy;
    assign head      = mem[rd_ptr[PW-1:0]];
    assign head_nxt  = mem[PW'(rd_ptr + ptr_t'(1))];

    // Prefix count gives each valid lane its compacted slot; the trap lands after all commits.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < CW; i++) begin
            slot[i] = n_push;
            if (push_valid[i]) n_push = n_push + ptr_t'(1);
        end
        slot[CW] = n_push;
        if (push_trap) n_push = n_push + ptr_t'(1);
        if (!accept) n_push = '0;
        count_nxt = occupancy + n_push - ptr_t'(pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + n_push;
            rd_ptr <= rd_ptr + ptr_t'(pop);
            ready  <= (ptr_t'(DEPTH) - count_nxt) >= ptr_t'(CW + 1);
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < CW; i++)
                if (push_valid[i])
                    mem[PW'(wr_ptr + slot[i])] <= '{trap: 1'b0, pc: CA_XLEN'(push_pc[i]),
                        inst: CA_INST_BITS'(push_inst[i]), wdata: CA_XLEN'(push_wdata[i])};
            if (push_trap)
                mem[PW'(wr_ptr + slot[CW])] <= '{trap: 1'b1, pc: '0, inst: '0,
                    wdata: CA_XLEN'(push_cause)};
        end
    end

    // Producers must respect ready; anything offered while not ready is dropped.
    assert property (@(posedge clock) disable iff (!reset_n)
        ((|push_valid) || push_trap) |-> ready);

endmodule

// File: rtl/cosim_commit_arbiter.sv
// Serialises per-hart retire/trap events into one ordered checker stream with round-robin fairness.
// Optional counters: define COSIM_ARB_STATS_EN.
module cosim_commit_arbiter
    import cosim_arb_pkg::*;
#(
    parameter int N_HARTS      = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = CA_XLEN,
    parameter int INST_BITS    = CA_INST_BITS,
    parameter int DEPTH        = 8,
    localparam int HW          = hart_w(N_HARTS)
) (
    input  logic                                                clock,
    input  logic                                                reset_n,
    input  logic [N_HARTS-1:0][COMMIT_WIDTH-1:0]                in_valid,
    input  logic [N_HARTS-1:0][COMMIT_WIDTH-1:0][XLEN-1:0]      in_pc,
    input  logic [N_HARTS-1:0][COMMIT_WIDTH-1:0][INST_BITS-1:0] in_inst,
    input  logic [N_HARTS-1:0][COMMIT_WIDTH-1:0][XLEN-1:0]      in_wdata,
    input  logic [N_HARTS-1:0]                                  in_trap,
    input  logic [N_HARTS-1:0][XLEN-1:0]                        in_cause,
    output logic [N_HARTS-1:0]                                  in_ready,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [HW-1:0]                                       out_hartid,
    output logic                                                out_trap,
    output logic [XLEN-1:0]                                     out_pc,
    output logic [INST_BITS-1:0]                                out_inst,
    output logic [XLEN-1:0]                                     out_wdata
`ifdef COSIM_ARB_STATS_EN
   ,output logic [N_HARTS-1:0][31:0]                            stat_commits,
    output logic [N_HARTS-1:0][31:0]                            stat_traps,
    output logic [31:0]                                         stat_stall
`endif
);

    localparam int OW = $clog2(DEPTH) + 1;

    arb_state_e                   state, state_nxt;
    logic [N_HARTS-1:0]           pop, req;
    logic [N_HARTS-1:0][OW-1:0]   occ, free_cnt;
    cosim_evt_t                   head [N_HARTS];
    cosim_evt_t                   head_nxt [N_HARTS];
    cosim_evt_t                   evt_q, sel_evt;
    logic [HW-1:0]                rr_ptr, grant_q, start, sel;
    logic                         sel_found, fire;

    function automatic logic [HW-1:0] next_hart(logic [HW-1:0] h);
        return (int'(h) == N_HARTS - 1) ? '0 : h + HW'(1);
    endfunction

    for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
        cosim_commit_fifo #(
            .CW(COMMIT_WIDTH), .DEPTH(DEPTH), .XLEN(XLEN), .INST_BITS(INST_BITS)
        ) u_fifo (
            .clock      (clock),
            .reset_n    (reset_n),
            .push_valid (in_valid[h]),
            .push_pc    (in_pc[h]),
            .push_inst  (in_inst[h]),
            .push_wdata (in_wdata[h]),
            .push_trap  (in_trap[h]),
            .push_cause (in_cause[h]),
            .pop        (pop[h]),
            .ready      (in_ready[h]),
            .head       (head[h]),
            .head_nxt   (head_nxt[h]),
            .occupancy  (occ[h]),
            .free       (free_cnt[h])
        );
    end

    // On a handshake the granted hart is judged by what remains after its pop, so one hart can stream 1/cycle.
    always_comb begin
        fire = out_valid & out_ready;
        pop  = '0;
        req  = '0;
        for (int h = 0; h < N_HARTS; h++)
            req[h] = free_cnt[h] != OW'(DEPTH);
        if (fire) begin
            pop[grant_q] = 1'b1;
            req[grant_q] = occ[grant_q] > OW'(1);
        end
        start     = fire ? next_hart(grant_q) : rr_ptr;
        sel       = '0;
        sel_found = 1'b0;
        for (int i = N_HARTS - 1; i >= 0; i--) begin
            int idx;
            idx = int'(start) + i;
            if (idx >= N_HARTS) idx = idx - N_HARTS;
            if (req[idx]) begin
                sel       = HW'(idx);
                sel_found = 1'b1;
            end
        end
        sel_evt = (fire && sel == grant_q) ? head_nxt[sel] : head[sel];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (sel_found) state_nxt = GRANT;
            GRANT, HOLD: state_nxt = !out_ready ? HOLD : (sel_found ? GRANT : IDLE);
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid  = state != IDLE;
        out_hartid = grant_q;
        out_trap   = evt_q.trap;
        out_pc     = XLEN'(evt_q.pc);
        out_inst   = INST_BITS'(evt_q.inst);
        out_wdata  = XLEN'(evt_q.wdata);
    end

    // Presented event is reloaded only when idle or on a handshake, so HOLD freezes it; zero when nothing is picked.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            evt_q   <= '0;
        end else begin
            if (fire) rr_ptr <= next_hart(grant_q);
            if (state == IDLE || fire) begin
                grant_q <= sel_found ? sel : '0;
                evt_q   <= sel_found ? sel_evt : '0;
            end
        end
    end

`ifdef COSIM_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_commits <= '0;
            stat_traps   <= '0;
            stat_stall   <= '0;
        end else begin
            if (fire && !evt_q.trap && stat_commits[grant_q] != '1)
                stat_commits[grant_q] <= stat_commits[grant_q] + 32'd1;
            if (fire && evt_q.trap && stat_traps[grant_q] != '1)
                stat_traps[grant_q] <= stat_traps[grant_q] + 32'd1;
            if (out_valid && !out_ready && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// Directed bench for cosim_commit_arbiter: per-hart scoreboard queues plus an occupancy model for in_ready.
module tb_cosim_commit_arbiter;

    typedef struct packed {
        logic        trap;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
    } ev_t;

    logic         clock = 1'b0, reset_n = 1'b0;
    logic [3:0]   in_valid = '0;
    logic [255:0] in_pc = '0, in_wdata = '0;
    logic [127:0] in_inst = '0, in_cause = '0;
    logic [1:0]   in_trap = '0;
    logic [1:0]   in_ready;
    logic         out_valid, out_ready = 1'b0, out_trap;
    logic [0:0]   out_hartid;
    logic [63:0]  out_pc, out_wdata;
    logic [31:0]  out_inst;

    ev_t          sbq [2][$];
    int           occ [2];
    int           npush [2];
    int           fire_hart [$];
    int           fire_cyc [$];
    int           n_cmp, n_err, cyc;
    logic [63:0]  pc_ctr = 64'h100;

    always #5 clock = ~clock;

    cosim_commit_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
        .in_trap(in_trap), .in_cause(in_cause), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_hartid(out_hartid),
        .out_trap(out_trap), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata)
    );

    task automatic chk(string tag, logic [191:0] got, logic [191:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a group to hart h if it is ready; expected events go to that hart's scoreboard in order.
    task automatic offer(int h, logic [1:0] v, logic tr, logic [63:0] cause);
        ev_t e;
        logic [63:0] pc;
        if (!in_ready[h]) return;
        for (int l = 0; l < 2; l++) begin
            if (v[l]) begin
                pc = pc_ctr;
                pc_ctr = pc_ctr + 64'd4;
                in_valid[h*2+l] = 1'b1;
                in_pc[(h*2+l)*64 +: 64]    = pc;
                in_inst[(h*2+l)*32 +: 32]  = pc[31:0] ^ 32'h0000_0013;
                in_wdata[(h*2+l)*64 +: 64] = ~pc;
                e = '{1'b0, pc, pc[31:0] ^ 32'h0000_0013, ~pc};
                sbq[h].push_back(e);
                npush[h]++;
            end
        end
        if (tr) begin
            in_trap[h] = 1'b1;
            in_cause[h*64 +: 64] = cause;
            e = '{1'b1, 64'h0, 32'h0, cause};
            sbq[h].push_back(e);
            npush[h]++;
        end
    endtask

    // One clock: check handshake/idle outputs before the edge, then in_ready after it.
    task automatic tick();
        logic fire;
        int   ph;
        ev_t  got;
        @(negedge clock);
        fire = reset_n && out_valid && out_ready;
        ph   = int'(out_hartid);
        if (reset_n && !out_valid)
            chk("idle_zero", 192'({out_hartid, out_trap, out_pc, out_inst, out_wdata}), 192'(0));
        if (fire) begin
            got = {out_trap, out_pc, out_inst, out_wdata};
            n_cmp++;
            assert (sbq[ph].size() > 0) else begin
                n_err++;
                $error("FAIL extra_evt: hart %0d emitted pc %0h, expected no event", ph, out_pc);
            end
            if (sbq[ph].size() > 0)
                chk($sformatf("evt_h%0d", ph), 192'(got), 192'(sbq[ph].pop_front()));
            fire_hart.push_back(ph);
            fire_cyc.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        for (int h = 0; h < 2; h++) begin
            if (!reset_n) begin
                occ[h] = 0;
                sbq[h].delete();
            end else begin
                occ[h] = occ[h] + npush[h] - ((fire && ph == h) ? 1 : 0);
            end
            npush[h] = 0;
            chk($sformatf("in_ready_h%0d", h), 192'(in_ready[h]), 192'((8 - occ[h]) >= 3));
        end
        in_valid = '0;
        in_trap  = '0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (!(sbq[0].size() == 0 && sbq[1].size() == 0 && !out_valid) && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (n < budget) else begin
            n_err++;
            $error("FAIL drain_timeout: %0d events outstanding after %0d cycles, required 0",
                   sbq[0].size() + sbq[1].size(), n);
        end
    endtask

    initial begin
        int b, s;
        logic [165:0] snap, now;

        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_out_valid", 192'(out_valid), 192'(0));
        chk("rst_in_ready", 192'(in_ready), 192'(2'b11));
        chk("rst_hartid", 192'(out_hartid), 192'(0));

        // Two lanes on one hart stream back to back.
        out_ready = 1'b1;
        pc_ctr = 64'h1000;
        b = fire_cyc.size();
        offer(0, 2'b11, 1'b0, 64'h0);
        tick();
        drain(20);
        chk("t1_count", 192'(fire_cyc.size() - b), 192'(2));
        if (fire_cyc.size() >= b + 2)
            chk("t1_b2b", 192'(fire_cyc[b+1] - fire_cyc[b]), 192'(1));

        // Lane 1 only plus a trap: commit first, then the trap carrying the cause.
        pc_ctr = 64'h2004;
        b = fire_cyc.size();
        offer(0, 2'b10, 1'b1, 64'h8000_0000_0000_0007);
        tick();
        drain(20);
        chk("t2_count", 192'(fire_cyc.size() - b), 192'(2));

        // Both harts saturated: grants must alternate.
        b = fire_hart.size();
        for (int i = 0; i < 16; i++) begin
            offer(0, 2'b11, 1'b0, 64'h0);
            offer(1, 2'b11, 1'b0, 64'h0);
            tick();
        end
        s = fire_hart.size();
        drain(60);
        chk("t3_fires", 192'((s - b) >= 12), 192'(1));
        for (int k = b + 1; k < s; k++)
            chk("rr_alt", 192'(fire_hart[k] != fire_hart[k-1]), 192'(1));

        // Five stalled cycles mid-stream: outputs frozen, hart 0 backs up until not ready.
        offer(0, 2'b11, 1'b0, 64'h0);
        offer(1, 2'b11, 1'b0, 64'h0);
        tick();
        tick();
        tick();
        chk("t4_valid", 192'(out_valid), 192'(1));
        out_ready = 1'b0;
        snap = {out_valid, out_hartid, out_trap, out_pc, out_inst, out_wdata};
        for (int i = 0; i < 5; i++) begin
            offer(0, 2'b11, 1'b0, 64'h0);
            tick();
            now = {out_valid, out_hartid, out_trap, out_pc, out_inst, out_wdata};
            chk("hold_stable", 192'(now), 192'(snap));
        end
        chk("t4_ready_drop", 192'(in_ready[0]), 192'(0));
        out_ready = 1'b1;
        drain(60);

        // Fill hart 0 to 7 entries, then push and pop together across the pointer wrap.
        out_ready = 1'b0;
        offer(0, 2'b01, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            offer(0, 2'b11, 1'b0, 64'h0);
            tick();
        end
        chk("t5_occ7_ready", 192'(in_ready[0]), 192'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            offer(0, 2'b11, 1'b0, 64'h0);
            tick();
        end
        drain(40);

        // Reset with four queued entries: nothing stale may come out afterwards.
        out_ready = 1'b0;
        offer(0, 2'b11, 1'b0, 64'h0);
        tick();
        offer(0, 2'b11, 1'b0, 64'h0);
        tick();
        tick();
        tick();
        chk("t6_held", 192'(out_valid), 192'(1));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_valid", 192'(out_valid), 192'(0));
        chk("t6_ready", 192'(in_ready), 192'(2'b11));
        b = fire_hart.size();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_stale", 192'(fire_hart.size() - b), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
